// File: rtl/rggen_bit_field_mode_if.sv
// Register access interface shared by the register and its bit fields.
// The host side drives the access strobes and data; each field drives its own read_data slice.
interface rggen_register_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] write_mask;
    logic [DATA_WIDTH-1:0] read_data;

    function automatic logic write_access();
        return write_en;
    endfunction

    function automatic logic read_access();
        return read_en;
    endfunction

    modport data (
        input  write_en, read_en, write_data, write_mask,
        output read_data,
        import write_access, read_access
    );

    modport host (
        output write_en, read_en, write_data, write_mask,
        input  read_data
    );
endinterface

// File: rtl/rggen_bit_field_mode.sv
// Register bit field with selectable software access mode and hardware set/load inputs.
// Optional registered access triggers are built when RGGEN_BIT_FIELD_TRIGGER_EN is defined.
module rggen_bit_field_mode #(
    parameter int             MSB           = 0,
    parameter int             LSB           = 0,
    parameter int             MODE          = 0,
    parameter logic [MSB-LSB:0] INITIAL_VALUE = '0,
    parameter bit             HW_SET_EN     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    rggen_register_if.data     register_if,
    input  logic [MSB-LSB:0]   i_set,
    input  logic               i_load,
    input  logic [MSB-LSB:0]   i_load_value,
    output logic [MSB-LSB:0]   o_value
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
    ,
    output logic [MSB-LSB:0]   o_write_trigger,
    output logic               o_read_trigger
`endif
);
    localparam int WIDTH = MSB - LSB + 1;

    typedef enum int {
        MODE_RW  = 0,
        MODE_W1C = 1,
        MODE_W1S = 2,
        MODE_RC  = 3,
        MODE_RO  = 4
    } mode_e;

    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] sw_value;
    logic [WIDTH-1:0] next_value;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] data;
    logic             write_hit;
    logic             read_hit;

    assign write_hit = register_if.write_access();
    assign read_hit  = register_if.read_access();
    assign mask      = register_if.write_mask[MSB:LSB];
    assign data      = register_if.write_data[MSB:LSB];
    assign set_bits  = HW_SET_EN ? i_set : '0;

    always_comb begin
        // NOTE: default to the held value first so no path leaves sw_value unassigned (no latch).
        sw_value = value;
        case (MODE)
            MODE_RW:  if (write_hit) sw_value = (value & ~mask) | (data & mask);
            MODE_W1C: if (write_hit) sw_value = value & ~(data & mask);
            MODE_W1S: if (write_hit) sw_value = value | (data & mask);
            // A write in the same cycle suppresses the read side effect.
            MODE_RC:  if (read_hit && !write_hit) sw_value = '0;
            default:  sw_value = value;
        endcase
    end

    // Load beats everything; set bits OR over the software result so events are never lost.
    assign next_value = i_load ? i_load_value : (sw_value | set_bits);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) value <= INITIAL_VALUE;
        else        value <= next_value;
    end

    assign o_value                      = value;
    assign register_if.read_data[MSB:LSB] = value;

`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_write_trigger <= '0;
            o_read_trigger  <= 1'b0;
        end else begin
            o_write_trigger <= mask & {WIDTH{write_hit}};
            o_read_trigger  <= read_hit;
        end
    end
`endif
endmodule

// File: tb/tb_rggen_bit_field_mode.sv
// Table-driven bench for rggen_bit_field_mode: six instances, one per mode/option mix,
// all fields placed at bits [11:4] (or [4:4] for the one-bit field) of a 16-bit register.
module tb_rggen_bit_field_mode;
    localparam int NDUT = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         sel = 0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] fd = '0;
    logic [7:0] fm = '0;
    logic [7:0] set_v = '0;
    logic       ld = 1'b0;
    logic [7:0] ld_v = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rggen_register_if #(.DATA_WIDTH(16)) rif [NDUT] ();

    logic [7:0] value [NDUT-1];
    logic [0:0] value5;
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
    logic [7:0] wtrig [NDUT-1];
    logic       rtrig [NDUT];
    logic [0:0] wtrig5;
`endif

    for (genvar k = 0; k < NDUT; k++) begin : g_bus
        assign rif[k].write_en   = wr_en && (sel == k);
        assign rif[k].read_en    = rd_en && (sel == k);
        assign rif[k].write_data = {4'h0, fd, 4'h0};
        assign rif[k].write_mask = (sel == k) ? {4'h0, fm, 4'h0} : 16'h0000;
    end

    rggen_bit_field_mode #(.MSB(11), .LSB(4), .MODE(0), .INITIAL_VALUE(8'hA5), .HW_SET_EN(1'b0)) u_rw (
        .clk(clk), .rst_n(rst_n), .register_if(rif[0]),
        .i_set((sel == 0) ? set_v : 8'h00), .i_load(ld && sel == 0), .i_load_value(ld_v), .o_value(value[0])
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        , .o_write_trigger(wtrig[0]), .o_read_trigger(rtrig[0])
`endif
    );
    rggen_bit_field_mode #(.MSB(11), .LSB(4), .MODE(1), .INITIAL_VALUE(8'hFF), .HW_SET_EN(1'b1)) u_w1c (
        .clk(clk), .rst_n(rst_n), .register_if(rif[1]),
        .i_set((sel == 1) ? set_v : 8'h00), .i_load(ld && sel == 1), .i_load_value(ld_v), .o_value(value[1])
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        , .o_write_trigger(wtrig[1]), .o_read_trigger(rtrig[1])
`endif
    );
    rggen_bit_field_mode #(.MSB(11), .LSB(4), .MODE(2), .INITIAL_VALUE(8'h00), .HW_SET_EN(1'b0)) u_w1s (
        .clk(clk), .rst_n(rst_n), .register_if(rif[2]),
        .i_set((sel == 2) ? set_v : 8'h00), .i_load(ld && sel == 2), .i_load_value(ld_v), .o_value(value[2])
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        , .o_write_trigger(wtrig[2]), .o_read_trigger(rtrig[2])
`endif
    );
    rggen_bit_field_mode #(.MSB(11), .LSB(4), .MODE(3), .INITIAL_VALUE(8'h00), .HW_SET_EN(1'b1)) u_rc (
        .clk(clk), .rst_n(rst_n), .register_if(rif[3]),
        .i_set((sel == 3) ? set_v : 8'h00), .i_load(ld && sel == 3), .i_load_value(ld_v), .o_value(value[3])
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        , .o_write_trigger(wtrig[3]), .o_read_trigger(rtrig[3])
`endif
    );
    rggen_bit_field_mode #(.MSB(11), .LSB(4), .MODE(4), .INITIAL_VALUE(8'h00), .HW_SET_EN(1'b0)) u_ro (
        .clk(clk), .rst_n(rst_n), .register_if(rif[4]),
        .i_set((sel == 4) ? set_v : 8'h00), .i_load(ld && sel == 4), .i_load_value(ld_v), .o_value(value[4])
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        , .o_write_trigger(wtrig[4]), .o_read_trigger(rtrig[4])
`endif
    );
    rggen_bit_field_mode #(.MSB(4), .LSB(4), .MODE(0), .INITIAL_VALUE(1'b0), .HW_SET_EN(1'b1)) u_rw1 (
        .clk(clk), .rst_n(rst_n), .register_if(rif[5]),
        .i_set((sel == 5) ? set_v[0:0] : 1'b0), .i_load(ld && sel == 5), .i_load_value(ld_v[0:0]), .o_value(value5)
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        , .o_write_trigger(wtrig5), .o_read_trigger(rtrig[5])
`endif
    );

    // Outputs of the currently selected instance, widened to 8 bits.
    logic [7:0] cur_value;
    logic [7:0] cur_read;
    logic [7:0] rd_slice [NDUT];
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
    logic [7:0] cur_wtrig;
    logic       cur_rtrig;
`endif
    for (genvar k = 0; k < NDUT; k++) begin : g_rd
        if (k == NDUT - 1) begin : g_one
            assign rd_slice[k] = {7'b0, rif[k].read_data[4]};
        end else begin : g_eight
            assign rd_slice[k] = rif[k].read_data[11:4];
        end
    end

    always_comb begin
        cur_value = (sel == 5) ? {7'b0, value5} : value[sel];
        cur_read  = rd_slice[sel];
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        cur_wtrig = (sel == 5) ? {7'b0, wtrig5} : wtrig[sel];
        cur_rtrig = rtrig[sel];
`endif
    end

    typedef struct {
        string      name;
        int         sel;
        logic       wr;
        logic       rd;
        logic [7:0] d;
        logic [7:0] m;
        logic [7:0] set;
        logic       ld;
        logic [7:0] lv;
        logic [7:0] exp_rd;
        logic [7:0] exp_v;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input int s, input logic w, input logic r,
                       input logic [7:0] d, input logic [7:0] m, input logic [7:0] st,
                       input logic l, input logic [7:0] lv,
                       input logic [7:0] erd, input logic [7:0] ev);
        vec_t v;
        v.name = name; v.sel = s; v.wr = w; v.rd = r; v.d = d; v.m = m; v.set = st;
        v.ld = l; v.lv = lv; v.exp_rd = erd; v.exp_v = ev;
        vecs.push_back(v);
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; fd = '0; fm = '0; set_v = '0; ld = 1'b0; ld_v = '0;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        sel = v.sel; wr_en = v.wr; rd_en = v.rd; fd = v.d; fm = v.m;
        set_v = v.set; ld = v.ld; ld_v = v.lv;
        #1 check({v.name, "/read"}, cur_read, v.exp_rd);
        @(posedge clk);
        #1 check({v.name, "/value"}, cur_value, v.exp_v);
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        check({v.name, "/wtrig"}, cur_wtrig, v.wr ? v.m : 8'h00);
        check({v.name, "/rtrig"}, cur_rtrig, v.rd);
`endif
        idle();
    endtask

    initial begin
        //   name          sel wr  rd  d      m      set    ld  lv     exp_rd exp_v
        add("rw_mask",      0, 1, 0, 8'h3C, 8'h0F, 8'h00, 0, 8'h00, 8'hA5, 8'hAC);
        add("rw_zero",      0, 1, 0, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 8'hAC, 8'h00);
        add("rw_5a",        0, 1, 0, 8'h5A, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h5A);
        add("rw_read",      0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h5A, 8'h5A);
        add("w1c_set_keep", 1, 1, 0, 8'hFF, 8'hFF, 8'h01, 0, 8'h00, 8'hFF, 8'h01);
        add("w1c_clear",    1, 1, 0, 8'hFF, 8'hFF, 8'h00, 0, 8'h00, 8'h01, 8'h00);
        add("w1c_set",      1, 0, 0, 8'h00, 8'h00, 8'h84, 0, 8'h00, 8'h00, 8'h84);
        add("w1c_mask",     1, 1, 0, 8'h04, 8'h0F, 8'h00, 0, 8'h00, 8'h84, 8'h80);
        add("w1c_load",     1, 1, 0, 8'hFF, 8'hFF, 8'h00, 1, 8'h3C, 8'h80, 8'h3C);
        add("w1s_set",      2, 1, 0, 8'h0F, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 8'h0F);
        add("w1s_mask",     2, 1, 0, 8'hF0, 8'h30, 8'h00, 0, 8'h00, 8'h0F, 8'h3F);
        add("w1s_load",     2, 1, 0, 8'hFF, 8'hFF, 8'h00, 1, 8'h00, 8'h3F, 8'h00);
        add("w1s_nomask",   2, 1, 0, 8'hFF, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        add("w1s_no_hwset", 2, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h00, 8'h00);
        add("rc_set",       3, 0, 0, 8'h00, 8'h00, 8'h12, 0, 8'h00, 8'h00, 8'h12);
        add("rc_read",      3, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h12, 8'h00);
        add("rc_read2",     3, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h00, 8'h00);
        add("rc_set2",      3, 0, 0, 8'h00, 8'h00, 8'h12, 0, 8'h00, 8'h00, 8'h12);
        add("rc_read_set",  3, 0, 1, 8'h00, 8'h00, 8'h40, 0, 8'h00, 8'h12, 8'h40);
        add("rc_rd_and_wr", 3, 1, 1, 8'hFF, 8'hFF, 8'h00, 0, 8'h00, 8'h40, 8'h40);
        add("rc_write",     3, 1, 0, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 8'h40, 8'h40);
        add("ro_load",      4, 0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h5A, 8'h00, 8'h5A);
        add("ro_write",     4, 1, 0, 8'h00, 8'hFF, 8'h00, 0, 8'h00, 8'h5A, 8'h5A);
        add("ro_read",      4, 0, 1, 8'h00, 8'h00, 8'h00, 0, 8'h00, 8'h5A, 8'h5A);
        add("ro_no_hwset",  4, 0, 0, 8'h00, 8'h00, 8'hFF, 0, 8'h00, 8'h5A, 8'h5A);
        add("w1_write1",    5, 1, 0, 8'h01, 8'h01, 8'h00, 0, 8'h00, 8'h00, 8'h01);
        add("w1_set_vs_0",  5, 1, 0, 8'h00, 8'h01, 8'h01, 0, 8'h00, 8'h01, 8'h01);
        add("w1_write0",    5, 1, 0, 8'h00, 8'h01, 8'h00, 0, 8'h00, 8'h01, 8'h00);
        add("w1_set",       5, 0, 0, 8'h00, 8'h00, 8'h01, 0, 8'h00, 8'h00, 8'h01);

        // Reset values, held in reset and after release.
        #12;
        check("rst_rw_value", value[0], 8'hA5);
        check("rst_rw_read", rif[0].read_data[11:4], 8'hA5);
        check("rst_w1c_value", value[1], 8'hFF);
        check("rst_rc_value", value[3], 8'h00);
        check("rst_w1_value", {7'b0, value5}, 8'h00);
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        check("rst_wtrig", wtrig[0], 8'h00);
        check("rst_rtrig", rtrig[0], 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_rw_value", value[0], 8'hA5);
        check("post_rst_rw_read", rif[0].read_data[11:4], 8'hA5);

        foreach (vecs[i]) apply(vecs[i]);

        // Trigger pulses last exactly one cycle; then reset lands in the middle of an access.
        @(negedge clk);
        sel = 0; wr_en = 1'b1; fd = 8'h00; fm = 8'hF0;
        @(posedge clk);
        #1 check("trig_wr_value", value[0], 8'h0A);
        idle();
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        check("trig_wr_pulse", wtrig[0], 8'hF0);
        @(posedge clk);
        #1 check("trig_wr_gone", wtrig[0], 8'h00);
`endif
        @(negedge clk);
        rd_en = 1'b1;
        @(posedge clk);
        #1 idle();
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        check("trig_rd_pulse", rtrig[0], 1'b1);
        @(posedge clk);
        #1 check("trig_rd_gone", rtrig[0], 1'b0);
`endif
        @(negedge clk);
        wr_en = 1'b1; rd_en = 1'b1; fd = 8'hFF; fm = 8'hFF;
        #1 rst_n = 1'b0;
        #1 check("mid_rst_value", value[0], 8'hA5);
        @(posedge clk);
        #1 check("mid_rst_hold", value[0], 8'hA5);
`ifdef RGGEN_BIT_FIELD_TRIGGER_EN
        check("mid_rst_wtrig", wtrig[0], 8'h00);
        check("mid_rst_rtrig", rtrig[0], 1'b0);
`endif
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("after_mid_rst", value[0], 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end
endmodule
